// File: rtl/vga_frame_scanout.sv
// 160x120x3 frame buffer with continuous 640x480@60 VGA scanout (4x4 pixel replication).
// Optional host readback port on the frame buffer when FB_READBACK_EN is defined.
module vga_frame_scanout #(
  parameter int X_RES   = 160,
  parameter int Y_RES   = 120,
  parameter int SCALE   = 4,
  parameter int COLOR_W = 3,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         x,
  input  logic [6:0]         y,
  input  logic [COLOR_W-1:0] color,
  input  logic               plot,
`ifdef FB_READBACK_EN
  input  logic [7:0]         rdX,
  input  logic [6:0]         rdY,
  input  logic               rdReq,
  output logic [COLOR_W-1:0] rdColor,
  output logic               rdValid,
`endif
  output logic [7:0]         vgaR,
  output logic [7:0]         vgaG,
  output logic [7:0]         vgaB,
  output logic               vgaHS,
  output logic               vgaVS,
  output logic               vgaBlankN,
  output logic               vgaClk,
  output logic               frameStart
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DEPTH = X_RES * Y_RES;
  localparam int AW    = $clog2(DEPTH);
  localparam int SH    = $clog2(SCALE);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [7:0]    X_LIM   = 8'(X_RES);
  localparam logic [6:0]    Y_LIM   = 7'(Y_RES);

  logic          pixEn;
  logic [HW-1:0] hCount;
  logic [VW-1:0] vCount;
  logic          fs0;

  logic          visible, hsN, vsN, wrEn;
  logic [AW-1:0] scanAddr, wrAddr;

  logic               vis1, hs1, vs1, fs1;
  logic [COLOR_W-1:0] pixData;
  logic [COLOR_W-1:0] mem [DEPTH];

  assign vgaClk = pixEn;

  // Stage 0: timing counters; fs0 marks the first clk the counters sit at (0,0) after a wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixEn  <= 1'b0;
      hCount <= '0;
      vCount <= '0;
      fs0    <= 1'b0;
    end else begin
      pixEn <= ~pixEn;
      fs0   <= 1'b0;
      if (pixEn) begin
        if (hCount == H_LAST) begin
          hCount <= '0;
          if (vCount == V_LAST) begin
            vCount <= '0;
            fs0    <= 1'b1;
          end else begin
            vCount <= vCount + 1'b1;
          end
        end else begin
          hCount <= hCount + 1'b1;
        end
      end
    end
  end

  always_comb begin
    visible  = (hCount < H_VIS_C) && (vCount < V_VIS_C);
    hsN      = !((hCount >= HS_BEG) && (hCount < HS_END));
    vsN      = !((vCount >= VS_BEG) && (vCount < VS_END));
    scanAddr = visible ? AW'(vCount >> SH) * AW'(X_RES) + AW'(hCount >> SH) : '0;
    wrEn     = plot && (x < X_LIM) && (y < Y_LIM);
    wrAddr   = AW'(y) * AW'(X_RES) + AW'(x);
  end

`ifdef FB_READBACK_EN
  logic          rbPend, rbHit, rbIn, rbGo, rbInRange;
  logic [7:0]    rbX, selX;
  logic [6:0]    rbY, selY;
  logic [AW-1:0] rbAddr;
  logic [COLOR_W-1:0] rbData;

  // Host reads use the pixEn=0 slot; a request landing on pixEn=1 is parked for one clk.
  always_comb begin
    selX      = rbPend ? rbX : rdX;
    selY      = rbPend ? rbY : rdY;
    rbGo      = (rdReq || rbPend) && !pixEn;
    rbInRange = (selX < X_LIM) && (selY < Y_LIM);
    rbAddr    = rbInRange ? AW'(selY) * AW'(X_RES) + AW'(selX) : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbPend  <= 1'b0;
      rbHit   <= 1'b0;
      rbIn    <= 1'b0;
      rbX     <= '0;
      rbY     <= '0;
      rdValid <= 1'b0;
      rdColor <= '0;
    end else begin
      rbHit   <= rbGo;
      rdValid <= rbHit;
      if (rbHit) rdColor <= rbIn ? rbData : '0;
      if (rbGo) begin
        rbPend <= 1'b0;
        rbIn   <= rbInRange;
      end else if (rdReq) begin
        rbPend <= 1'b1;
        rbX    <= rdX;
        rbY    <= rdY;
      end
    end
  end
`endif

  // Frame buffer is never reset; non-blocking read gives old data on a same-address write.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= color;
    pixData <= mem[scanAddr];
`ifdef FB_READBACK_EN
    if (rbGo) rbData <= mem[rbAddr];
`endif
  end

  // Stages 1 and 2 keep syncs, blank, frameStart aligned with the RAM read latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vis1       <= 1'b0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      fs1        <= 1'b0;
      vgaR       <= '0;
      vgaG       <= '0;
      vgaB       <= '0;
      vgaHS      <= 1'b1;
      vgaVS      <= 1'b1;
      vgaBlankN  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      vis1       <= visible;
      hs1        <= hsN;
      vs1        <= vsN;
      fs1        <= fs0;
      vgaR       <= vis1 ? {8{pixData[2]}} : '0;
      vgaG       <= vis1 ? {8{pixData[1]}} : '0;
      vgaB       <= vis1 ? {8{pixData[0]}} : '0;
      vgaHS      <= hs1;
      vgaVS      <= vs1;
      vgaBlankN  <= vis1;
      frameStart <= fs1;
    end
  end

endmodule
